data_mem_arbiter: RTL and testbench

//  Owns the single data-memory port between the MEM-stage pipeline access and a debug memory-dump sequencer.

---
 rtl/data_mem_arbiter_pkg.sv | 23 ++
 rtl/data_mem_arbiter_mem_dump_counter.sv | 40 ++++
 rtl/data_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared state encoding and sizing helpers for the data-memory arbiter
package data_mem_arbiter_pkg;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_READ = 2'd1;
  localparam logic [1:0] ENC_SEND = 2'd2;
  localparam logic [1:0] ENC_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_READ = ENC_READ,
    ST_SEND = ENC_SEND,
    ST_DONE = ENC_DONE
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int WORD_SHIFT = $clog2(WORD_BYTES);

  function automatic int cnt_width(input int n_words);
    return (n_words > 1) ? $clog2(n_words) : 1;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_mem_dump_counter.sv
// rtl/data_mem_arbiter_mem_dump_counter.sv - word index for the memory dump, saturating at the last word
module mem_dump_counter
  import data_mem_arbiter_pkg::*;
#(
  parameter int NB_ADDR = 32,
  parameter int N_WORDS = 32,
  localparam int NB_CNT = cnt_width(N_WORDS)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_incr,
  output logic               o_last,
  output logic [NB_ADDR-1:0] o_byte_addr
);

  logic [NB_CNT-1:0] count_q;
  logic [NB_CNT-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_incr && !o_last) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_last      = (count_q == NB_CNT'(N_WORDS - 1));
  assign o_byte_addr = NB_ADDR'(count_q) << WORD_SHIFT;

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares the data-memory port between the MEM stage and a debug dump sequencer
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int NB_ADDR = 32,
  parameter int NB_DATA = 32,
  parameter int N_WORDS = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_pipe_mem_read,
  input  logic               i_pipe_mem_write,
  input  logic               i_pipe_word_en,
  input  logic               i_pipe_halfword_en,
  input  logic               i_pipe_byte_en,
  input  logic [NB_ADDR-1:0] i_pipe_addr,
  input  logic [NB_DATA-1:0] i_pipe_write_data,
  output logic [NB_DATA-1:0] o_pipe_read_data,
  output logic               o_pipe_stall,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_mem_word_en,
  output logic               o_mem_halfword_en,
  output logic               o_mem_byte_en,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_write_data,
  input  logic [NB_DATA-1:0] i_mem_read_data,
  input  logic               i_dbg_halted,
  input  logic               i_dbg_dump_start,
  input  logic               i_dbg_ready,
  output logic               o_dbg_valid,
  output logic [NB_DATA-1:0] o_dbg_data,
  output logic [NB_ADDR-1:0] o_dbg_addr,
  output logic               o_dbg_busy,
  output logic               o_dbg_done
);

  state_e               state_q;
  state_e               state_d;
  logic [NB_DATA-1:0]   data_q;
  logic [NB_DATA-1:0]   data_d;
  logic                 cnt_clear;
  logic                 cnt_incr;
  logic                 cnt_last;
  logic [NB_ADDR-1:0]   dump_addr;

  mem_dump_counter #(
    .NB_ADDR(NB_ADDR),
    .N_WORDS(N_WORDS)
  ) u_counter (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (cnt_clear),
    .i_incr     (cnt_incr),
    .o_last     (cnt_last),
    .o_byte_addr(dump_addr)
  );

  always_comb begin
    state_d           = state_q;
    data_d            = data_q;
    cnt_clear         = 1'b0;
    cnt_incr          = 1'b0;
    o_mem_read        = 1'b0;
    o_mem_write       = 1'b0;
    o_mem_word_en     = 1'b0;
    o_mem_halfword_en = 1'b0;
    o_mem_byte_en     = 1'b0;
    o_mem_addr        = '0;
    o_mem_write_data  = '0;
    o_pipe_stall      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        o_mem_read        = i_pipe_mem_read;
        o_mem_write       = i_pipe_mem_write;
        o_mem_word_en     = i_pipe_word_en;
        o_mem_halfword_en = i_pipe_halfword_en;
        o_mem_byte_en     = i_pipe_byte_en;
        o_mem_addr        = i_pipe_addr;
        o_mem_write_data  = i_pipe_write_data;
        if (i_dbg_dump_start && i_dbg_halted) begin
          state_d   = ST_READ;
          cnt_clear = 1'b1;
        end
      end
      ST_READ: begin
        o_mem_read    = 1'b1;
        o_mem_word_en = 1'b1;
        o_mem_addr    = dump_addr;
        data_d        = i_mem_read_data;
        state_d       = ST_SEND;
      end
      ST_SEND: begin
        if (i_dbg_ready) begin
          if (cnt_last) begin
            state_d = ST_DONE;
          end else begin
            cnt_incr = 1'b1;
            state_d  = ST_READ;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Any pipeline access while the sequencer owns the port is refused, not queued.
    if (state_q != ST_IDLE) begin
      o_pipe_stall = i_pipe_mem_read | i_pipe_mem_write;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign o_pipe_read_data = i_mem_read_data;
  assign o_dbg_valid      = (state_q == ST_SEND);
  assign o_dbg_data       = data_q;
  assign o_dbg_addr       = dump_addr;
  assign o_dbg_busy       = (state_q != ST_IDLE);
  assign o_dbg_done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter against a dump-sequence model
module tb_data_mem_arbiter;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_read, pipe_write, word_en, half_en, byte_en;
  logic [31:0] pipe_addr, pipe_wdata;
  logic        halted, dump_start, ready;
  logic [31:0] o_pipe_read_data, o_mem_addr, o_mem_write_data, i_mem_read_data;
  logic        o_pipe_stall, o_mem_read, o_mem_write, o_mem_word_en, o_mem_halfword_en, o_mem_byte_en;
  logic        o_dbg_valid, o_dbg_busy, o_dbg_done;
  logic [31:0] o_dbg_data, o_dbg_addr;

  logic [31:0] tb_mem [0:N-1];
  logic [31:0] exp_mem [0:N-1];
  logic [31:0] beat_a[$];
  logic [31:0] beat_d[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_mem_write) tb_mem[o_mem_addr[6:2]] <= o_mem_write_data;
  end
  assign i_mem_read_data = tb_mem[o_mem_addr[6:2]];

  data_mem_arbiter #(.NB_ADDR(32), .NB_DATA(32), .N_WORDS(N)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_pipe_mem_read(pipe_read), .i_pipe_mem_write(pipe_write),
    .i_pipe_word_en(word_en), .i_pipe_halfword_en(half_en), .i_pipe_byte_en(byte_en),
    .i_pipe_addr(pipe_addr), .i_pipe_write_data(pipe_wdata),
    .o_pipe_read_data(o_pipe_read_data), .o_pipe_stall(o_pipe_stall),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_word_en(o_mem_word_en), .o_mem_halfword_en(o_mem_halfword_en), .o_mem_byte_en(o_mem_byte_en),
    .o_mem_addr(o_mem_addr), .o_mem_write_data(o_mem_write_data), .i_mem_read_data(i_mem_read_data),
    .i_dbg_halted(halted), .i_dbg_dump_start(dump_start), .i_dbg_ready(ready),
    .o_dbg_valid(o_dbg_valid), .o_dbg_data(o_dbg_data), .o_dbg_addr(o_dbg_addr),
    .o_dbg_busy(o_dbg_busy), .o_dbg_done(o_dbg_done)
  );

  task automatic pipe_idle();
    pipe_read = 0; pipe_write = 0; word_en = 0; half_en = 0; byte_en = 0;
    pipe_addr = 0; pipe_wdata = 0;
  endtask

  // Memory is loaded through the pipeline store path while the arbiter is idle.
  task automatic fill_mem(input int mode);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      pipe_write = 1; word_en = 1; pipe_addr = i * 4;
      pipe_wdata = (mode == 0) ? i * 32'h11 : $urandom;
      exp_mem[i] = pipe_wdata;
    end
    @(negedge clk);
    pipe_idle();
  endtask

  // mode 0: ready tied high; 1: random ready with 5 forced low cycles on word 3;
  // 2: ready high, halted drops and a second start arrives mid-dump.
  task automatic run_dump(input int mode, output int done_cycle, output int mem_reads,
                          output int unstable, output int low_cycles);
    logic [31:0] pd, pa;
    bit held;
    int hold3;
    beat_a.delete(); beat_d.delete();
    done_cycle = -1; mem_reads = 0; unstable = 0; low_cycles = 0;
    held = 0; hold3 = 0; pd = 0; pa = 0;
    @(negedge clk);
    dump_start = 1; halted = 1; ready = 1;
    for (int k = 1; k < 400; k++) begin
      @(negedge clk);
      dump_start = 0;
      if (mode == 2 && k == 3) halted = 0;
      if (mode == 2 && k == 10) dump_start = 1;
      if (mode == 1) begin
        if (o_dbg_valid && o_dbg_addr == 32'hC && hold3 < 5) begin
          ready = 0; hold3++;
        end else begin
          ready = ($urandom_range(0, 3) != 0);
        end
      end else begin
        ready = 1;
      end
      #2;
      if (o_mem_read) mem_reads++;
      if (o_dbg_valid) begin
        if (held && (o_dbg_data !== pd || o_dbg_addr !== pa)) unstable++;
        if (ready) begin
          beat_a.push_back(o_dbg_addr); beat_d.push_back(o_dbg_data); held = 0;
        end else begin
          held = 1; pd = o_dbg_data; pa = o_dbg_addr; low_cycles++;
        end
      end
      if (o_dbg_done) begin
        done_cycle = k;
        break;
      end
    end
    dump_start = 0; halted = 1; ready = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; pipe_idle(); halted = 0; dump_start = 0; ready = 0;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if ({o_dbg_busy, o_dbg_valid, o_dbg_done, o_pipe_stall, o_mem_read, o_mem_write} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=000000",
               {o_dbg_busy, o_dbg_valid, o_dbg_done, o_pipe_stall, o_mem_read, o_mem_write});
    end
    checks++;
    if (o_dbg_data !== 32'h0 || o_dbg_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_dbg_regs got data=%h addr=%h want 0/0", o_dbg_data, o_dbg_addr);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_passthrough();
    logic pr, pw, we, he, be;
    logic [31:0] pa, pd;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pr = 1'($urandom); pw = 1'($urandom); we = 1'($urandom); he = 1'($urandom); be = 1'($urandom);
      pa = $urandom; pd = $urandom;
      pipe_read = pr; pipe_write = pw; word_en = we; half_en = he; byte_en = be;
      pipe_addr = pa; pipe_wdata = pd;
      #2;
      checks++;
      if ({o_mem_read, o_mem_write, o_mem_word_en, o_mem_halfword_en, o_mem_byte_en,
           o_mem_addr, o_mem_write_data, o_pipe_stall} !== {pr, pw, we, he, be, pa, pd, 1'b0}) begin
        errors++;
        $display("FAIL passthrough_%0d got ctl=%b addr=%h wd=%h stall=%b want ctl=%b addr=%h wd=%h stall=0",
                 i, {o_mem_read, o_mem_write, o_mem_word_en, o_mem_halfword_en, o_mem_byte_en},
                 o_mem_addr, o_mem_write_data, o_pipe_stall, {pr, pw, we, he, be}, pa, pd);
      end
    end
    @(negedge clk);
    pipe_idle(); pipe_write = 1; word_en = 1; pipe_addr = 32'h8; pipe_wdata = 32'hDEADBEEF;
    @(negedge clk);
    pipe_idle(); pipe_read = 1; word_en = 1; pipe_addr = 32'h8;
    #2;
    checks++;
    if (o_pipe_read_data !== 32'hDEADBEEF || o_pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL load_after_store got=%h stall=%b want=deadbeef stall=0", o_pipe_read_data, o_pipe_stall);
    end
    @(negedge clk);
    pipe_idle();
  endtask

  task automatic test_full_dump(input int mode, input string tag);
    int dc, mr, us, lc, bad;
    fill_mem(0);
    run_dump(mode, dc, mr, us, lc);
    bad = 0;
    for (int i = 0; i < beat_a.size() && i < N; i++)
      if (beat_a[i] !== 32'(i * 4) || beat_d[i] !== exp_mem[i]) bad++;
    checks++;
    if (beat_a.size() != N || bad != 0) begin
      errors++;
      $display("FAIL %s_beats got count=%0d bad=%0d want count=%0d bad=0", tag, beat_a.size(), bad, N);
    end
    checks++;
    if (dc != 2 * N + 1) begin
      errors++;
      $display("FAIL %s_done_cycle got=%0d want=%0d", tag, dc, 2 * N + 1);
    end
    checks++;
    if (mr != N) begin
      errors++;
      $display("FAIL %s_mem_reads got=%0d want=%0d", tag, mr, N);
    end
    @(negedge clk);
    #2;
    checks++;
    if (o_dbg_busy !== 1'b0 || o_dbg_done !== 1'b0 || o_dbg_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_back_to_idle got busy=%b done=%b valid=%b want 0/0/0", tag, o_dbg_busy, o_dbg_done, o_dbg_valid);
    end
  endtask

  task automatic test_backpressure();
    int dc, mr, us, lc, bad;
    fill_mem(1);
    run_dump(1, dc, mr, us, lc);
    bad = 0;
    for (int i = 0; i < beat_a.size() && i < N; i++)
      if (beat_a[i] !== 32'(i * 4) || beat_d[i] !== exp_mem[i]) bad++;
    checks++;
    if (beat_a.size() != N || bad != 0) begin
      errors++;
      $display("FAIL bp_beats got count=%0d bad=%0d want count=%0d bad=0", beat_a.size(), bad, N);
    end
    checks++;
    if (us != 0) begin
      errors++;
      $display("FAIL bp_stable got unstable=%0d want=0", us);
    end
    checks++;
    if (mr != N) begin
      errors++;
      $display("FAIL bp_mem_reads got=%0d want=%0d", mr, N);
    end
    checks++;
    if (lc < 5 || dc != 2 * N + 1 + lc) begin
      errors++;
      $display("FAIL bp_done_cycle got=%0d low=%0d want=%0d low>=5", dc, lc, 2 * N + 1 + lc);
    end
  endtask

  task automatic test_ignored_start();
    @(negedge clk);
    pipe_idle(); halted = 0; dump_start = 1; ready = 1;
    @(negedge clk);
    dump_start = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (o_dbg_busy !== 1'b0 || o_dbg_valid !== 1'b0 || o_mem_read !== 1'b0) begin
        errors++;
        $display("FAIL start_not_halted_%0d got busy=%b valid=%b rd=%b want 0/0/0", i, o_dbg_busy, o_dbg_valid, o_mem_read);
      end
      @(negedge clk);
    end
    halted = 1;
  endtask

  task automatic test_stall();
    bit seen;
    fill_mem(1);
    @(negedge clk);
    pipe_idle(); pipe_read = 1; word_en = 1; pipe_addr = 32'h8;
    dump_start = 1; halted = 1; ready = 0;
    #2;
    checks++;
    if (o_pipe_stall !== 1'b0 || o_mem_read !== 1'b1 || o_mem_addr !== 32'h8 || o_pipe_read_data !== exp_mem[2]) begin
      errors++;
      $display("FAIL same_cycle_pipe got stall=%b rd=%b addr=%h data=%h want 0/1/00000008/%h",
               o_pipe_stall, o_mem_read, o_mem_addr, o_pipe_read_data, exp_mem[2]);
    end
    @(negedge clk);
    dump_start = 0; pipe_idle(); pipe_write = 1; word_en = 1; pipe_addr = 32'h10; pipe_wdata = 32'h1234;
    #2;
    checks++;
    if (o_dbg_busy !== 1'b1 || o_pipe_stall !== 1'b1 || o_mem_write !== 1'b0 || o_mem_read !== 1'b1 ||
        o_mem_addr !== 32'h0 || o_mem_write_data !== 32'h0) begin
      errors++;
      $display("FAIL read_blocks_store got busy=%b stall=%b wr=%b rd=%b addr=%h wd=%h want 1/1/0/1/0/0",
               o_dbg_busy, o_pipe_stall, o_mem_write, o_mem_read, o_mem_addr, o_mem_write_data);
    end
    @(negedge clk);
    pipe_idle(); pipe_read = 1; word_en = 1; pipe_addr = 32'h10;
    #2;
    checks++;
    if (o_dbg_valid !== 1'b1 || o_pipe_stall !== 1'b1 || o_mem_read !== 1'b0 || o_dbg_data !== exp_mem[0]) begin
      errors++;
      $display("FAIL send_stalls_load got valid=%b stall=%b rd=%b data=%h want 1/1/0/%h",
               o_dbg_valid, o_pipe_stall, o_mem_read, o_dbg_data, exp_mem[0]);
    end
    @(negedge clk);
    pipe_idle(); ready = 1;
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      #2;
      if (o_dbg_done) seen = 1;
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stall_dump_finish got done=0 within 200 cycles want done=1");
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    int dones, dc, mr, us, lc, bad;
    fill_mem(1);
    @(negedge clk);
    dump_start = 1; halted = 1; ready = 1;
    hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      dump_start = 0;
      #2;
      if (o_dbg_valid && o_dbg_addr == 32'h28) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach_word10 got no beat at 0x28 want one");
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if (o_dbg_busy !== 1'b0 || o_dbg_valid !== 1'b0 || o_dbg_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async got busy=%b valid=%b done=%b want 0/0/0", o_dbg_busy, o_dbg_valid, o_dbg_done);
    end
    @(negedge clk);
    rst_n = 1;
    dones = 0;
    for (int k = 0; k < 70; k++) begin
      #2;
      if (o_dbg_done || o_dbg_busy) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done got active_cycles=%0d want=0", dones);
    end
    run_dump(0, dc, mr, us, lc);
    bad = 0;
    for (int i = 0; i < beat_a.size() && i < N; i++)
      if (beat_a[i] !== 32'(i * 4) || beat_d[i] !== exp_mem[i]) bad++;
    checks++;
    if (beat_a.size() != N || bad != 0 || dc != 2 * N + 1) begin
      errors++;
      $display("FAIL reset_mid_restart got count=%0d bad=%0d done=%0d first=%h want %0d/0/%0d/00000000",
               beat_a.size(), bad, dc, (beat_a.size() > 0) ? beat_a[0] : 32'hFFFFFFFF, N, 2 * N + 1);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_full_dump(0, "dump");
    test_backpressure();
    test_ignored_start();
    test_full_dump(2, "dump_halt_drop");
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
